// File: rtl/draw_sched_pkg.sv
// Shared types and constants for the draw scheduler: FSM states, screen size,
// coordinate/colour widths and the watchdog counter width.
package draw_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_NEXT,
        ST_FRAME_DONE
    } state_e;

    localparam int unsigned SCREEN_W  = 320;
    localparam int unsigned SCREEN_H  = 240;
    localparam int unsigned X_W       = 9;
    localparam int unsigned Y_W       = 8;
    localparam int unsigned COLOR_W   = 12;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned WDT_CNT_W = 17;

endpackage

// File: rtl/draw_scheduler_next_client_sel.sv
// Combinational search for the lowest set mask bit strictly above from_i.
// from_i = -1 yields the lowest set bit overall.
module next_client_sel
    import draw_sched_pkg::*;
#(
    parameter int unsigned N_CLIENTS = 4
) (
    input  logic [N_CLIENTS-1:0]  mask_i,
    input  logic signed [IDX_W:0] from_i,
    output logic [IDX_W-1:0]      next_idx_o,
    output logic                  found_o
);

    logic             found;
    logic [IDX_W-1:0] next_idx;

    always_comb begin
        found    = 1'b0;
        next_idx = '0;
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            if (!found && mask_i[i] && ($signed({1'b0, IDX_W'(i)}) > from_i)) begin
                found    = 1'b1;
                next_idx = IDX_W'(i);
            end
        end
    end

    assign next_idx_o = next_idx;
    assign found_o    = found;

endmodule

// File: rtl/draw_scheduler.sv
// Per-frame sequencer and framebuffer write-port arbiter for the draw clients.
// Optional per-client watchdog built only when DRAW_WATCHDOG_EN is defined.
module draw_scheduler
    import draw_sched_pkg::*;
#(
    parameter int unsigned N_CLIENTS  = 4,
    parameter int unsigned SCREEN_W   = draw_sched_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H   = draw_sched_pkg::SCREEN_H,
    parameter int unsigned WDT_CYCLES = 65536
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         frame_tick,
    input  logic [N_CLIENTS-1:0]         client_mask,
    input  logic [X_W*N_CLIENTS-1:0]     client_x,
    input  logic [Y_W*N_CLIENTS-1:0]     client_y,
    input  logic [COLOR_W*N_CLIENTS-1:0] client_color,
    input  logic [N_CLIENTS-1:0]         client_we,
    input  logic [N_CLIENTS-1:0]         client_done,
    output logic [N_CLIENTS-1:0]         client_start,
    output logic [X_W-1:0]               vga_x,
    output logic [Y_W-1:0]               vga_y,
    output logic [COLOR_W-1:0]           vga_color,
    output logic                         vga_we,
    output logic                         busy,
    output logic                         frame_done,
    output logic [IDX_W-1:0]             cur_client,
    output logic [7:0]                   overrun_cnt,
    output logic [N_CLIENTS-1:0]         timeout_flags
);

    if (N_CLIENTS < 1 || N_CLIENTS > 8) begin : g_bad_n
        $error("draw_scheduler: N_CLIENTS must be 1..8");
    end
    if (WDT_CYCLES < 1 || WDT_CYCLES > (2 ** WDT_CNT_W)) begin : g_bad_wdt
        $error("draw_scheduler: WDT_CYCLES out of range");
    end

    state_e                 state_q, state_d;
    logic [N_CLIENTS-1:0]   mask_q, mask_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [N_CLIENTS-1:0]   start_q, start_d;
    logic [N_CLIENTS-1:0]   tflags_q, tflags_d;
    logic                   frame_done_q;
    logic [7:0]             overrun_q;
    logic [X_W-1:0]         vga_x_q;
    logic [Y_W-1:0]         vga_y_q;
    logic [COLOR_W-1:0]     vga_color_q;
    logic                   vga_we_q, vga_we_d;

    logic [N_CLIENTS-1:0]   sel_mask;
    logic signed [IDX_W:0]  sel_from;
    logic [IDX_W-1:0]       nxt_idx;
    logic                   nxt_found;
    logic                   timeout;

    logic [X_W-1:0]         sel_x;
    logic [Y_W-1:0]         sel_y;
    logic [COLOR_W-1:0]     sel_color;
    logic                   sel_we;
    logic                   sel_done;

    // In IDLE the search runs over the live mask from -1 so the first client
    // is known in the same cycle the frame is accepted.
    assign sel_mask = (state_q == ST_IDLE) ? client_mask : mask_q;
    assign sel_from = (state_q == ST_IDLE) ? '1 : $signed({1'b0, idx_q});

    next_client_sel #(
        .N_CLIENTS (N_CLIENTS)
    ) u_next_client_sel (
        .mask_i     (sel_mask),
        .from_i     (sel_from),
        .next_idx_o (nxt_idx),
        .found_o    (nxt_found)
    );

    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_color = '0;
        sel_we    = 1'b0;
        sel_done  = 1'b0;
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            if (32'(idx_q) == i) begin
                sel_x     = client_x[i*X_W +: X_W];
                sel_y     = client_y[i*Y_W +: Y_W];
                sel_color = client_color[i*COLOR_W +: COLOR_W];
                sel_we    = client_we[i];
                sel_done  = client_done[i];
            end
        end
    end

`ifdef DRAW_WATCHDOG_EN
    logic [WDT_CNT_W-1:0] wdt_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wdt_q <= '0;
        end else if (state_q == ST_START) begin
            wdt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            wdt_q <= wdt_q + WDT_CNT_W'(1);
        end
    end

    assign timeout = (state_q == ST_WAIT) && (wdt_q == WDT_CNT_W'(WDT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        idx_d    = idx_q;
        start_d  = '0;
        tflags_d = tflags_q;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    mask_d   = client_mask;
                    tflags_d = '0;
                    if (nxt_found) begin
                        idx_d   = nxt_idx;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_FRAME_DONE;
                    end
                end
            end
            ST_START: begin
                start_d = N_CLIENTS'(1) << idx_q;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // start_q is the registered strobe, so a done arriving while it
                // is high coincides with the start pulse and is not taken.
                if (timeout) begin
                    tflags_d = tflags_q | (N_CLIENTS'(1) << idx_q);
                    state_d  = ST_NEXT;
                end else if (sel_done && (start_q == '0)) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (nxt_found) begin
                    idx_d   = nxt_idx;
                    state_d = ST_START;
                end else begin
                    state_d = ST_FRAME_DONE;
                end
            end
            ST_FRAME_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign vga_we_d = (state_q == ST_WAIT) && sel_we && !timeout
                      && (32'(sel_x) < SCREEN_W) && (32'(sel_y) < SCREEN_H);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            idx_q        <= '0;
            start_q      <= '0;
            tflags_q     <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_color_q  <= '0;
            vga_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            idx_q        <= idx_d;
            start_q      <= start_d;
            tflags_q     <= tflags_d;
            frame_done_q <= (state_q == ST_FRAME_DONE);
            vga_x_q      <= sel_x;
            vga_y_q      <= sel_y;
            vga_color_q  <= sel_color;
            vga_we_q     <= vga_we_d;
            if ((state_q != ST_IDLE) && frame_tick && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end
        end
    end

    assign client_start  = start_q;
    assign vga_x         = vga_x_q;
    assign vga_y         = vga_y_q;
    assign vga_color     = vga_color_q;
    assign vga_we        = vga_we_q;
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = frame_done_q;
    assign cur_client    = idx_q;
    assign overrun_cnt   = overrun_q;
    assign timeout_flags = tflags_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: expected starts, writes and frame_done
// pulses are queued when stimulus is driven and checked as the DUT produces them.
module tb_draw_scheduler;

`ifdef DRAW_WATCHDOG_EN
    localparam int unsigned TB_WDT = 100;
`else
    localparam int unsigned TB_WDT = 65536;
`endif
    localparam int unsigned N = 4;

    logic          clock;
    logic          resetn;
    logic          frame_tick;
    logic [N-1:0]  client_mask;
    logic [9*N-1:0]  client_x;
    logic [8*N-1:0]  client_y;
    logic [12*N-1:0] client_color;
    logic [N-1:0]  client_we;
    logic [N-1:0]  client_done;
    logic [N-1:0]  client_start;
    logic [8:0]    vga_x;
    logic [7:0]    vga_y;
    logic [11:0]   vga_color;
    logic          vga_we;
    logic          busy;
    logic          frame_done;
    logic [2:0]    cur_client;
    logic [7:0]    overrun_cnt;
    logic [N-1:0]  timeout_flags;

    draw_scheduler #(
        .N_CLIENTS  (N),
        .WDT_CYCLES (TB_WDT)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .frame_tick    (frame_tick),
        .client_mask   (client_mask),
        .client_x      (client_x),
        .client_y      (client_y),
        .client_color  (client_color),
        .client_we     (client_we),
        .client_done   (client_done),
        .client_start  (client_start),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_color     (vga_color),
        .vga_we        (vga_we),
        .busy          (busy),
        .frame_done    (frame_done),
        .cur_client    (cur_client),
        .overrun_cnt   (overrun_cnt),
        .timeout_flags (timeout_flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int n_starts = 0;
    int n_fd     = 0;

    int          exp_start[$];
    logic [28:0] exp_wr[$];
    int          exp_fd[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every strobe.
    always @(negedge clock) begin
        if (resetn) begin
            if (client_start != '0) begin
                n_starts++;
                if (exp_start.size() == 0) check("start_unexpected", 32'(client_start), 32'd0);
                else check("start_idx", 32'(client_start), 32'(1) << exp_start.pop_front());
            end
            if (vga_we) begin
                if (exp_wr.size() == 0) check("write_unexpected", {3'd0, vga_x, vga_y, vga_color}, 32'd0);
                else check("write_xyc", {3'd0, vga_x, vga_y, vga_color}, {3'd0, exp_wr.pop_front()});
            end
            if (frame_done) begin
                n_fd++;
                if (exp_fd.size() == 0) check("frame_done_unexpected", 32'd1, 32'd0);
                else void'(exp_fd.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "tb_draw_scheduler: time limit");
    end

    task automatic pulse_tick(input logic [N-1:0] m);
        client_mask = m;
        frame_tick  = 1'b1;
        @(negedge clock);
        frame_tick  = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clock);
            if (client_start != '0) seen = 1'b1;
        end
        if (!seen) check(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_fd(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clock);
            if (frame_done) seen = 1'b1;
        end
        if (!seen) check(tag, 32'd0, 32'd1);
    endtask

    task automatic done_pulse(input int i);
        @(negedge clock);
        client_done[i] = 1'b1;
        @(negedge clock);
        client_done = '0;
    endtask

    task automatic set_px(input int i, input logic [8:0] x, input logic [7:0] y, input logic [11:0] c);
        client_x[i*9 +: 9]      = x;
        client_y[i*8 +: 8]      = y;
        client_color[i*12 +: 12] = c;
    endtask

    task automatic write_px(input int i, input logic [8:0] x, input logic [7:0] y,
                            input logic [11:0] c, input bit expect_wr);
        if (expect_wr) exp_wr.push_back({x, y, c});
        set_px(i, x, y, c);
        client_we[i] = 1'b1;
        @(negedge clock);
        client_we = '0;
    endtask

    initial begin
        int lat;
        resetn       = 1'b0;
        frame_tick   = 1'b0;
        client_mask  = '0;
        client_x     = '0;
        client_y     = '0;
        client_color = '0;
        client_we    = '0;
        client_done  = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(client_start), 32'd0);
        check("rst_we", 32'(vga_we), 32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);
        check("rst_cur", 32'(cur_client), 32'd0);
        check("rst_tflags", 32'(timeout_flags), 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        // Two-client frame, clients 0 and 2.
        n_starts = 0;
        exp_start.push_back(0); exp_start.push_back(2); exp_fd.push_back(1);
        pulse_tick(4'b0101);
        wait_start("t1_start0_wait");
        check("t1_cur0", 32'(cur_client), 32'd0);
        done_pulse(0);
        wait_start("t1_start2_wait");
        check("t1_cur2", 32'(cur_client), 32'd2);
        done_pulse(2);
        wait_fd("t1_fd_wait");
        check("t1_start_count", 32'(n_starts), 32'd2);

        // Write forwarding and off-screen clipping on client 1.
        exp_start.push_back(1); exp_fd.push_back(1);
        pulse_tick(4'b0010);
        wait_start("t2_start1_wait");
        set_px(0, 9'd7, 8'd7, 12'h111);
        client_we[0] = 1'b1;
        write_px(1, 9'd100, 8'd50, 12'hBBB, 1'b1);
        write_px(1, 9'd330, 8'd10, 12'h123, 1'b0);
        write_px(1, 9'd10, 8'd245, 12'h456, 1'b0);
        write_px(1, 9'd319, 8'd239, 12'hA5C, 1'b1);
        client_we[0] = 1'b1;
        @(negedge clock);
        client_we = '0;
        done_pulse(1);
        wait_fd("t2_fd_wait");
        check("t2_writes_left", 32'(exp_wr.size()), 32'd0);

        // Empty mask: frame_done two clocks after the tick.
        n_starts = 0;
        exp_fd.push_back(1);
        pulse_tick(4'b0000);
        lat = 0;
        for (int k = 2; k < 20 && lat == 0; k++) begin
            @(negedge clock);
            if (frame_done) lat = k;
        end
        check("t4_fd_latency", 32'(lat), 32'd2);
        check("t4_no_start", 32'(n_starts), 32'd0);

        // Ticks while busy are counted and do not disturb the running frame.
        n_starts = 0;
        exp_start.push_back(0); exp_fd.push_back(1);
        pulse_tick(4'b0001);
        wait_start("t5_start_wait");
        repeat (3) begin
            pulse_tick(4'b1111);
            @(negedge clock);
        end
        check("t5_overrun", 32'(overrun_cnt), 32'd3);
        done_pulse(0);
        wait_fd("t5_fd_wait");
        check("t5_start_count", 32'(n_starts), 32'd1);

        // done coinciding with the start pulse is ignored.
        exp_start.push_back(3); exp_fd.push_back(1);
        pulse_tick(4'b1000);
        wait_start("t7_start_wait");
        client_done[3] = 1'b1;
        lat = n_fd;
        @(negedge clock);
        client_done = '0;
        repeat (3) @(negedge clock);
        check("t7_still_busy", 32'(busy), 32'd1);
        check("t7_no_fd", 32'(n_fd), 32'(lat));
        done_pulse(3);
        wait_fd("t7_fd_wait");

`ifdef DRAW_WATCHDOG_EN
        // Client 1 never finishes: watchdog flags it and moves on to client 2.
        exp_start.push_back(1); exp_start.push_back(2); exp_fd.push_back(1);
        pulse_tick(4'b0110);
        wait_start("t6_start1_wait");
        lat = 0;
        for (int k = 1; k < 400 && lat == 0; k++) begin
            @(negedge clock);
            if (client_start != '0) lat = k;
        end
        check("t6_wdt_latency", 32'(lat), 32'(TB_WDT + 2));
        check("t6_tflags", 32'(timeout_flags), 32'b0010);
        done_pulse(2);
        wait_fd("t6_fd_wait");
        exp_fd.push_back(1);
        pulse_tick(4'b0000);
        check("t6_tflags_clear", 32'(timeout_flags), 32'd0);
        wait_fd("t6_fd2_wait");
`else
        check("t6_tflags_zero", 32'(timeout_flags), 32'd0);
`endif

        // Reset in the middle of WAIT: no partial frame_done, outputs cleared.
        n_starts = 0;
        exp_start.push_back(0);
        pulse_tick(4'b0011);
        wait_start("t8_start_wait");
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        check("t8_busy", 32'(busy), 32'd0);
        check("t8_start", 32'(client_start), 32'd0);
        check("t8_fd", 32'(frame_done), 32'd0);
        check("t8_we", 32'(vga_we), 32'd0);
        check("t8_cur", 32'(cur_client), 32'd0);
        check("t8_overrun", 32'(overrun_cnt), 32'd0);
        resetn = 1'b1;
        repeat (8) @(negedge clock);
        check("t8_start_count", 32'(n_starts), 32'd1);
        check("t8_idle", 32'(busy), 32'd0);

        check("sb_start_left", 32'(exp_start.size()), 32'd0);
        check("sb_write_left", 32'(exp_wr.size()), 32'd0);
        check("sb_fd_left", 32'(exp_fd.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
